// File: rtl/hamming_enc_seq_if.sv
// Opcode package and handshake/ALU bus for the (16,11) SECDED encoder sequencer.
// Optional ALU arbitration signals appear when HAMSEQ_ARB_EN is defined.
package hamming_enc_seq_pkg;
  localparam int DATA_W   = 8;
  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    ADD = 4'h0,
    XOR = 4'h6,
    RXR = 4'hC
  } op_mne;
endpackage

interface hamming_enc_seq_if;
  logic                                    in_valid;
  logic                                    in_ready;
  logic [10:0]                             in_data;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [15:0]                             out_data;
  logic [hamming_enc_seq_pkg::OPCODE_W-1:0] alu_op;
  logic [hamming_enc_seq_pkg::DATA_W-1:0]   alu_a;
  logic [hamming_enc_seq_pkg::DATA_W-1:0]   alu_b;
  logic [hamming_enc_seq_pkg::DATA_W-1:0]   alu_out;
  logic                                    busy;
`ifdef HAMSEQ_ARB_EN
  logic                                    alu_req;
  logic                                    alu_gnt;
`endif

  // master: the sequencer; slave: message source, codeword sink and ALU
  modport master (
    input  in_valid, in_data, out_ready, alu_out,
`ifdef HAMSEQ_ARB_EN
    input  alu_gnt,
    output alu_req,
`endif
    output in_ready, out_valid, out_data, alu_op, alu_a, alu_b, busy
  );

  modport slave (
    output in_valid, in_data, out_ready, alu_out,
`ifdef HAMSEQ_ARB_EN
    output alu_gnt,
    input  alu_req,
`endif
    input  in_ready, out_valid, out_data, alu_op, alu_a, alu_b, busy
  );
endinterface

// File: rtl/hamming_enc_seq.sv
// (16,11) SECDED Hamming encoder that borrows the shared 8-bit ALU, three steps per parity bit.
// Define HAMSEQ_ARB_EN to add alu_req/alu_gnt arbitration; otherwise the ALU is always granted.
module hamming_enc_seq
  import hamming_enc_seq_pkg::*;
#(
  parameter int W    = DATA_W,
  parameter int OP_W = OPCODE_W
) (
  input  logic              clk,
  input  logic              rst,
  hamming_enc_seq_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      s_reg;
  logic [15:0]     cw_reg;
  logic            t_lo_reg, t_hi_reg;
  logic            out_valid_reg;

  logic            gnt;
  logic [2:0]      grp;
  logic [1:0]      ph;
  logic [15:0]     mask;
  logic [3:0]      pos;
  logic [15:0]     masked;
  logic [OP_W-1:0] alu_op_c;
  logic [W-1:0]    alu_a_c, alu_b_c;

`ifdef HAMSEQ_ARB_EN
  assign gnt         = bus.alu_gnt;
  assign bus.alu_req = (state_reg == RUN);
`else
  assign gnt = 1'b1;
`endif

  assign grp = 3'(s_reg / 4'd3);
  assign ph  = 2'(s_reg % 4'd3);

  always_comb begin
    mask = 16'hFFFE;
    pos  = 4'd0;
    case (grp)
      3'd0:    begin mask = 16'hFF00; pos = 4'd8; end
      3'd1:    begin mask = 16'hF0F0; pos = 4'd4; end
      3'd2:    begin mask = 16'hCCCC; pos = 4'd2; end
      3'd3:    begin mask = 16'hAAAA; pos = 4'd1; end
      default: begin mask = 16'hFFFE; pos = 4'd0; end
    endcase
  end

  assign masked = cw_reg & mask;

  always_comb begin
    state_next = state_reg;
    alu_op_c   = ADD;
    alu_a_c    = '0;
    alu_b_c    = '0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        // Operands reflect the pending step even while the ALU is not granted
        case (ph)
          2'd0: begin
            alu_op_c = RXR;
            alu_a_c  = masked[7:0];
          end
          2'd1: begin
            alu_op_c = RXR;
            alu_a_c  = masked[15:8];
          end
          default: begin
            alu_op_c = XOR;
            alu_a_c  = {{(W-1){1'b0}}, t_lo_reg};
            alu_b_c  = {{(W-1){1'b0}}, t_hi_reg};
          end
        endcase
        if (gnt && s_reg == 4'd14) state_next = DONE;
      end
      DONE: begin
        if (out_valid_reg && bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg         <= 4'd0;
      cw_reg        <= 16'd0;
      t_lo_reg      <= 1'b0;
      t_hi_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            // Data bits go straight to their codeword positions; parity slots start at 0
            cw_reg <= {bus.in_data[10:4], 1'b0, bus.in_data[3:1], 1'b0,
                       bus.in_data[0], 3'b000};
            s_reg  <= 4'd0;
          end
        end
        RUN: begin
          if (gnt) begin
            case (ph)
              2'd0:    t_lo_reg    <= bus.alu_out[0];
              2'd1:    t_hi_reg    <= bus.alu_out[0];
              default: cw_reg[pos] <= bus.alu_out[0];
            endcase
            s_reg <= (s_reg == 4'd14) ? 4'd0 : s_reg + 4'd1;
          end
        end
        DONE: begin
          // out_valid rises one cycle after DONE entry and drops on the handshake
          if (!out_valid_reg)        out_valid_reg <= 1'b1;
          else if (bus.out_ready)    out_valid_reg <= 1'b0;
        end
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = cw_reg;
  assign bus.alu_op    = alu_op_c;
  assign bus.alu_a     = alu_a_c;
  assign bus.alu_b     = alu_b_c;

endmodule
